classic_game_core: RTL and testbench

Control core for the memory game's classic mode. It decodes the 2-bit mode selector into one-hot mode enables and compares the stored game pattern against the player's guess. It also runs the classic-mode round FSM, which drives the pattern generator, input handler and score logic. It sits between the top-level buttons/switches and the datapath blocks (RNG, pattern shift register, input handler).

---
 rtl/classic_game_core_if.sv | 39 +++
 rtl/classic_game_core.sv | 124 ++++++++++++
 tb/tb_classic_game_core.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/classic_game_core_if.sv
// Signal bundle between the classic-mode control core and the buttons/datapath.
// The master side drives the controls and patterns; the core is the slave.
interface classic_game_core_if #(
  parameter int MAX_ROUNDS = 25,
  parameter int SYM_W      = 3
);
  localparam int PAT_W = MAX_ROUNDS * SYM_W;
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);

  logic [1:0]       sel;
  logic             start;
  logic             play_again;
  logic             received_input;
  logic [PAT_W-1:0] game_pattern;
  logic [PAT_W-1:0] input_pattern;

  logic             start_classic;
  logic             start_time;
  logic             start_reverse;
  logic             is_equal;
  logic             gen_pattern;
  logic             incr_score;
  logic             clr;
  logic             input_handler_en;
  logic             game_over;
  logic [RND_W-1:0] round;

  modport master (
    output sel, start, play_again, received_input, game_pattern, input_pattern,
    input  start_classic, start_time, start_reverse, is_equal, gen_pattern,
           incr_score, clr, input_handler_en, game_over, round
  );

  modport slave (
    input  sel, start, play_again, received_input, game_pattern, input_pattern,
    output start_classic, start_time, start_reverse, is_equal, gen_pattern,
           incr_score, clr, input_handler_en, game_over, round
  );
endinterface

// File: rtl/classic_game_core.sv
// Classic-mode control core: registered mode decode, pattern comparator and
// round FSM. rst_n is asynchronous and active-HIGH despite its name.
module classic_game_core #(
  parameter int MAX_ROUNDS = 25,
  parameter int SYM_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  classic_game_core_if.slave  bus
);
  localparam int PAT_W = MAX_ROUNDS * SYM_W;
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT_IN,
    S_GAME_OVER,
    S_RESTART
  } state_t;

  state_t           state, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             start_classic, start_time, start_reverse;
  logic             is_equal;
  logic             gen_pattern, incr_score, clr, input_handler_en, game_over;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      start_classic <= 1'b0;
      start_time    <= 1'b0;
      start_reverse <= 1'b0;
    end else begin
      start_classic <= (bus.sel == 2'b00);
      start_time    <= (bus.sel == 2'b01);
      start_reverse <= (bus.sel == 2'b10);
    end
  end

  assign is_equal = bus.received_input &&
                    (bus.game_pattern[PAT_W-1:0] == bus.input_pattern[PAT_W-1:0]);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= S_IDLE;
      round_q <= '0;
    end else begin
      state   <= state_d;
      round_q <= round_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d          = state;
    gen_pattern      = 1'b0;
    incr_score       = 1'b0;
    clr              = 1'b0;
    input_handler_en = 1'b0;
    game_over        = 1'b0;
    unique case (state)
      S_IDLE: begin
        clr = 1'b1;
        if (bus.start) state_d = S_GEN;
      end
      S_GEN: begin
        gen_pattern = 1'b1;
        state_d     = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        input_handler_en = 1'b1;
        if (bus.received_input) begin
          if (is_equal) begin
            incr_score = 1'b1;
            state_d    = (round_q == LAST_ROUND) ? S_GAME_OVER : S_GEN;
          end else begin
            state_d = S_GAME_OVER;
          end
        end
      end
      S_GAME_OVER: begin
        game_over = 1'b1;
        if (bus.play_again) state_d = S_RESTART;
      end
      S_RESTART: begin
        clr     = 1'b1;
        state_d = S_GEN;
      end
      default: state_d = S_IDLE;
    endcase
    // Leaving classic mode aborts the game from any state, and no score is
    // awarded on the way out.
    if (!start_classic) begin
      state_d    = S_IDLE;
      incr_score = 1'b0;
    end
  end

  // round tracks the pattern length as seen in the state being entered, so
  // it already reads the new length during the GEN cycle.
  always_comb begin
    round_d = round_q;
    case (state_d)
      S_GEN:             if (round_q < LAST_ROUND) round_d = round_q + 1'b1;
      S_IDLE, S_RESTART: round_d = '0;
      default:           round_d = round_q;
    endcase
  end

  assign bus.start_classic    = start_classic;
  assign bus.start_time       = start_time;
  assign bus.start_reverse    = start_reverse;
  assign bus.is_equal         = is_equal;
  assign bus.gen_pattern      = gen_pattern;
  assign bus.incr_score       = incr_score;
  assign bus.clr              = clr;
  assign bus.input_handler_en = input_handler_en;
  assign bus.game_over        = game_over;
  assign bus.round            = round_q;
endmodule

// File: tb/tb_classic_game_core.sv
// Bench for classic_game_core: directed scenarios pinned with literal values,
// then randomized play, all compared every cycle against a game-level model.
module tb_classic_game_core;
  localparam int MAX_ROUNDS = 25;
  localparam int SYM_W      = 3;
  localparam int PAT_W      = MAX_ROUNDS * SYM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  classic_game_core_if #(.MAX_ROUNDS(MAX_ROUNDS), .SYM_W(SYM_W)) bus ();

  classic_game_core #(.MAX_ROUNDS(MAX_ROUNDS), .SYM_W(SYM_W)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Game-level model: which phase of a game we are in and how long the
  // pattern is, plus the mode selection as registered one cycle ago.
  typedef enum {P_IDLE, P_APPEND, P_GUESS, P_OVER, P_RESTART} phase_t;
  phase_t     m_phase = P_IDLE;
  int         m_len   = 0;
  logic [1:0] m_sel   = 2'b11;
  bit         m_classic;
  bit         m_match;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_len   = 0;
      m_sel   = 2'b11;
    end else begin
      m_classic = (m_sel == 2'b00);
      m_match   = bus.received_input && (bus.game_pattern == bus.input_pattern);
      m_sel     = bus.sel;
      if (!m_classic) begin
        m_phase = P_IDLE;
        m_len   = 0;
      end else begin
        case (m_phase)
          P_IDLE:    if (bus.start) begin m_phase = P_APPEND; m_len = 1; end
          P_APPEND:  m_phase = P_GUESS;
          P_GUESS:
            if (bus.received_input) begin
              if (m_match && m_len < MAX_ROUNDS) begin
                m_phase = P_APPEND;
                m_len   = m_len + 1;
              end else begin
                m_phase = P_OVER;
              end
            end
          P_OVER:    if (bus.play_again) begin m_phase = P_RESTART; m_len = 0; end
          P_RESTART: begin m_phase = P_APPEND; m_len = 1; end
          default:   m_phase = P_IDLE;
        endcase
      end
    end
  end

  function automatic logic [13:0] expected_outputs();
    bit eq, classic;
    classic = (m_sel == 2'b00);
    eq      = bus.received_input && (bus.game_pattern == bus.input_pattern);
    return {classic, m_sel == 2'b01, m_sel == 2'b10, eq,
            m_phase == P_APPEND, (m_phase == P_GUESS) && classic && eq,
            (m_phase == P_IDLE) || (m_phase == P_RESTART),
            m_phase == P_GUESS, m_phase == P_OVER, 5'(m_len)};
  endfunction

  always @(negedge clk) begin
    check("cycle_outputs",
          {bus.start_classic, bus.start_time, bus.start_reverse, bus.is_equal,
           bus.gen_pattern, bus.incr_score, bus.clr, bus.input_handler_en,
           bus.game_over, bus.round},
          expected_outputs());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [PAT_W-1:0] rand_pat();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[PAT_W-1:0];
  endfunction

  logic [PAT_W-1:0] one_bit;
  logic [2:0]       mode_exp [4];
  int               gens, guesses;
  bit               won;

  initial begin
    one_bit = 1;
    mode_exp[0] = 3'b100; mode_exp[1] = 3'b010; mode_exp[2] = 3'b001; mode_exp[3] = 3'b000;
    bus.sel = 2'b01; bus.start = 1'b0; bus.play_again = 1'b0; bus.received_input = 1'b0;
    bus.game_pattern = rand_pat();
    bus.input_pattern = bus.game_pattern;

    repeat (3) tick();
    mid();
    check("reset_modes", {bus.start_classic, bus.start_time, bus.start_reverse}, 3'b000);
    check("reset_clr", bus.clr, 1'b1);
    check("reset_round", bus.round, 0);
    tick();
    rst = 1'b0;

    for (int s = 0; s < 4; s++) begin
      bus.sel = 2'(s);
      tick(); tick(); mid();
      check("mode_decode", {bus.start_classic, bus.start_time, bus.start_reverse}, mode_exp[s]);
    end

    bus.received_input = 1'b0; #1;
    check("cmp_no_input", bus.is_equal, 1'b0);
    bus.received_input = 1'b1; #1;
    check("cmp_equal", bus.is_equal, 1'b1);
    bus.input_pattern = bus.game_pattern ^ (one_bit << 74); #1;
    check("cmp_bit74", bus.is_equal, 1'b0);
    bus.received_input = 1'b0;
    bus.input_pattern = bus.game_pattern;

    // Start held for four cycles starts exactly one game.
    bus.sel = 2'b00;
    tick(); tick();
    bus.start = 1'b1;
    gens = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); mid();
      gens += int'(bus.gen_pattern);
      if (i == 0) check("start_round1", bus.round, 1);
      if (i == 1) check("start_handler_en", bus.input_handler_en, 1'b1);
    end
    bus.start = 1'b0;
    check("start_one_gen", gens, 1);

    bus.play_again = 1'b1;
    tick(); mid();
    check("play_again_ignored", {bus.input_handler_en, bus.game_over}, 2'b10);
    bus.play_again = 1'b0;

    // Correct guess, then a wrong guess raised during GEN that only counts in WAIT_IN.
    bus.received_input = 1'b1; #1;
    check("good_guess_score", bus.incr_score, 1'b1);
    tick();
    bus.input_pattern = bus.game_pattern ^ (one_bit << 74);
    mid();
    check("regen_after_score", {bus.gen_pattern, bus.incr_score, 5'(bus.round)}, {2'b10, 5'd2});
    tick(); mid();
    check("gen_input_ignored", {bus.input_handler_en, bus.game_over, bus.incr_score}, 3'b100);
    tick();
    bus.received_input = 1'b0;
    bus.input_pattern = bus.game_pattern;
    mid();
    check("wrong_guess_over", {bus.game_over, 5'(bus.round)}, {1'b1, 5'd2});

    bus.start = 1'b1;
    tick(); mid();
    check("start_ignored_over", bus.game_over, 1'b1);
    bus.start = 1'b0;

    bus.play_again = 1'b1;
    tick();
    bus.play_again = 1'b0;
    mid();
    check("restart_clr", {bus.clr, bus.gen_pattern, 5'(bus.round)}, {2'b10, 5'd0});
    tick(); mid();
    check("restart_gen", {bus.gen_pattern, 5'(bus.round)}, {1'b1, 5'd1});
    tick(); mid();
    check("restart_handler_en", bus.input_handler_en, 1'b1);

    // Play to a win; bounded in case the game never ends.
    guesses = 0;
    won = 1'b0;
    for (int k = 0; k < 40 && !won; k++) begin
      bus.received_input = 1'b1;
      tick();
      bus.received_input = 1'b0;
      guesses++;
      mid();
      if (bus.game_over) won = 1'b1;
      else begin tick(); mid(); end
    end
    check("win_reached", won, 1'b1);
    check("win_round", bus.round, 25);
    check("win_guesses", guesses, 25);

    // Leave classic mode mid-game.
    bus.play_again = 1'b1;
    tick();
    bus.play_again = 1'b0;
    tick(); tick();
    bus.sel = 2'b01;
    tick(); mid();
    check("abort_mode", {bus.start_classic, bus.start_time, bus.input_handler_en}, 3'b011);
    tick(); mid();
    check("abort_idle", {bus.clr, bus.input_handler_en, 5'(bus.round)}, {2'b10, 5'd0});

    // Asynchronous reset in the middle of a game.
    bus.sel = 2'b00;
    tick(); tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); mid();
    #2 rst = 1'b1;
    #1;
    check("async_reset", {bus.clr, bus.input_handler_en, bus.start_classic, 5'(bus.round)},
          {3'b100, 5'd0});
    tick();
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.sel            = ($urandom_range(0, 99) < 97) ? 2'b00 : 2'($urandom_range(0, 3));
      bus.start          = ($urandom_range(0, 3) == 0);
      bus.play_again     = ($urandom_range(0, 5) == 0);
      bus.received_input = ($urandom_range(0, 2) == 0);
      bus.game_pattern   = rand_pat();
      bus.input_pattern  = ($urandom_range(0, 9) < 8) ? bus.game_pattern
                           : bus.game_pattern ^ (one_bit << $urandom_range(0, PAT_W - 1));
      rst                = ($urandom_range(0, 499) == 0);
    end
    tick();
    rst = 1'b0;
    mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
